// File: rtl/mem_stage.sv
// Memory-access stage: byte-enabled data memory, LL/SC link register, sticky halt,
// and the registered write-back bundle handed to the register file.
module mem_stage #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned REG_WORDS = 32,
  parameter int unsigned ADDR_LEFT = $clog2(REG_WORDS) - 1,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               sel_mem_s4,
  input  logic               mem_rw_s4,
  input  logic               load_link_s4,
  input  logic               check_link_s4,
  input  logic               rw_s4,
  input  logic [ADDR_LEFT:0] waddr_s4,
  input  logic [3:0]         byte_en_s4,
  input  logic [BITS-1:0]    r2_data_s4,
  input  logic [BITS-1:0]    alu_out_s4,
  input  logic               halt_s4,
  output logic               rw_s5,
  output logic [ADDR_LEFT:0] waddr_s5,
  output logic [BITS-1:0]    wdata_s5,
  output logic               halt_s5,
  output logic               link_valid
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  logic [BITS-1:0]    mem_q [MEM_WORDS];
  logic [IdxW-1:0]    idx;
  logic [BITS-1:0]    lane_mask;
  logic [BITS-1:0]    load_data;
  logic               is_sc;
  logic               sc_ok;
  logic               mem_we;
  logic [BITS-1:0]    wdata_d;

  logic               rw_q;
  logic [ADDR_LEFT:0] waddr_q;
  logic [BITS-1:0]    wdata_q;
  logic               halted_q;
  logic               link_valid_q;
  logic [IdxW-1:0]    link_addr_q;

  // Upper address bits wrap; byte offset bits are ignored.
  assign idx = alu_out_s4[IdxW+1:2];

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{byte_en_s4[i]}};
    end
  end

  assign load_data = mem_q[idx] & lane_mask;
  assign is_sc     = mem_rw_s4 & check_link_s4;
  assign sc_ok     = link_valid_q & (link_addr_q == idx);
  // Gating on rst_ drops a store whose clock edge lands while reset is held.
  assign mem_we    = rst_ & ~halted_q & mem_rw_s4 & (~check_link_s4 | sc_ok);

  always_comb begin
    wdata_d = alu_out_s4;
    if (is_sc) begin
      wdata_d = {{(BITS-1){1'b0}}, sc_ok};
    end else if (sel_mem_s4) begin
      wdata_d = load_data;
    end
  end

  // Data array has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s4[i]) begin
          mem_q[idx][8*i +: 8] <= r2_data_s4[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rw_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      halted_q     <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      rw_q     <= rw_s4 & ~halted_q;
      waddr_q  <= waddr_s4;
      wdata_q  <= wdata_d;
      halted_q <= halted_q | halt_s4;
      if (!halted_q) begin
        if (is_sc || (mem_rw_s4 && (idx == link_addr_q))) begin
          link_valid_q <= 1'b0;
        end
        if (sel_mem_s4 && load_link_s4) begin
          link_valid_q <= 1'b1;
          link_addr_q  <= idx;
        end
      end
    end
  end

  assign rw_s5      = rw_q;
  assign waddr_s5   = waddr_q;
  assign wdata_s5   = wdata_q;
  assign halt_s5    = halted_q;
  assign link_valid = link_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a word-array/link/halt reference model.
module tb_mem_stage;

  localparam int unsigned MemWords = 256;

  logic        clk = 1'b0;
  logic        rst_;
  logic        sel_mem_s4, mem_rw_s4, load_link_s4, check_link_s4, rw_s4, halt_s4;
  logic [4:0]  waddr_s4;
  logic [3:0]  byte_en_s4;
  logic [31:0] r2_data_s4, alu_out_s4;
  logic        rw_s5, halt_s5, link_valid;
  logic [4:0]  waddr_s5;
  logic [31:0] wdata_s5;

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl_mem [MemWords];
  bit          mdl_lv;
  int unsigned mdl_la;
  bit          mdl_halted;

  mem_stage dut (
    .clk          (clk),
    .rst_         (rst_),
    .sel_mem_s4   (sel_mem_s4),
    .mem_rw_s4    (mem_rw_s4),
    .load_link_s4 (load_link_s4),
    .check_link_s4(check_link_s4),
    .rw_s4        (rw_s4),
    .waddr_s4     (waddr_s4),
    .byte_en_s4   (byte_en_s4),
    .r2_data_s4   (r2_data_s4),
    .alu_out_s4   (alu_out_s4),
    .halt_s4      (halt_s4),
    .rw_s5        (rw_s5),
    .waddr_s5     (waddr_s5),
    .wdata_s5     (wdata_s5),
    .halt_s5      (halt_s5),
    .link_valid   (link_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // One instruction through s4; outputs checked one clock later.
  task automatic step(input logic sm, input logic mrw, input logic ll, input logic cl,
                      input logic rw, input logic [4:0] wa, input logic [3:0] be,
                      input logic [31:0] r2, input logic [31:0] alu, input logic h);
    int unsigned idx;
    logic [31:0] m, exp_wd;
    bit is_sc, ok, exp_rw;
    sel_mem_s4 = sm; mem_rw_s4 = mrw; load_link_s4 = ll; check_link_s4 = cl;
    rw_s4 = rw; waddr_s4 = wa; byte_en_s4 = be; r2_data_s4 = r2; alu_out_s4 = alu;
    halt_s4 = h;
    idx    = (alu >> 2) % MemWords;
    m      = lanes(be);
    is_sc  = mrw && cl;
    ok     = mdl_lv && (mdl_la == idx);
    exp_wd = is_sc ? {31'b0, ok} : (sm ? (mdl_mem[idx] & m) : alu);
    exp_rw = rw && !mdl_halted;
    if (!mdl_halted) begin
      if (mrw && (!cl || ok)) mdl_mem[idx] = (mdl_mem[idx] & ~m) | (r2 & m);
      if (is_sc || (mrw && idx == mdl_la)) mdl_lv = 0;
      if (sm && ll) begin
        mdl_lv = 1;
        mdl_la = idx;
      end
    end
    if (h) mdl_halted = 1;
    @(posedge clk);
    #1;
    check("rw_s5", {31'b0, rw_s5}, {31'b0, exp_rw});
    check("waddr_s5", {27'b0, waddr_s5}, {27'b0, wa});
    check("wdata_s5", wdata_s5, exp_wd);
    check("halt_s5", {31'b0, halt_s5}, {31'b0, mdl_halted});
    check("link_valid", {31'b0, link_valid}, {31'b0, mdl_lv});
  endtask

  task automatic ld(input logic [31:0] a, input logic [3:0] be);
    step(1, 0, 0, 0, 1, 5'd3, be, 32'h0, a, 0);
  endtask
  task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    step(0, 1, 0, 0, 0, 5'd0, be, d, a, 0);
  endtask
  task automatic lnk(input logic [31:0] a);
    step(1, 0, 1, 0, 1, 5'd4, 4'hF, 32'h0, a, 0);
  endtask
  task automatic sc(input logic [31:0] a, input logic [31:0] d);
    step(0, 1, 0, 1, 1, 5'd5, 4'hF, d, a, 0);
  endtask

  // Reset held across a clock edge with a store pending: the store must be dropped.
  task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
    sel_mem_s4 = 0; mem_rw_s4 = 1; load_link_s4 = 0; check_link_s4 = 0; rw_s4 = 1;
    waddr_s4 = 5'd9; byte_en_s4 = 4'hF; r2_data_s4 = d; alu_out_s4 = a; halt_s4 = 0;
    #1;
    rst_ = 1'b0;
    #1;
    mdl_lv = 0; mdl_la = 0; mdl_halted = 0;
    check("rst_async_rw", {31'b0, rw_s5}, 32'd0);
    check("rst_async_halt", {31'b0, halt_s5}, 32'd0);
    check("rst_async_link", {31'b0, link_valid}, 32'd0);
    check("rst_async_wdata", wdata_s5, 32'd0);
    @(posedge clk);
    #2;
    rst_ = 1'b1;
    check("rst_hold_waddr", {27'b0, waddr_s5}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned op;
    rst_ = 1'b0;
    sel_mem_s4 = 0; mem_rw_s4 = 0; load_link_s4 = 0; check_link_s4 = 0; rw_s4 = 0;
    waddr_s4 = '0; byte_en_s4 = '0; r2_data_s4 = '0; alu_out_s4 = '0; halt_s4 = 0;
    mdl_lv = 0; mdl_la = 0; mdl_halted = 0;
    for (int i = 0; i < MemWords; i++) mdl_mem[i] = '0;
    #12;
    check("reset_rw", {31'b0, rw_s5}, 32'd0);
    check("reset_waddr", {27'b0, waddr_s5}, 32'd0);
    check("reset_wdata", wdata_s5, 32'd0);
    check("reset_halt", {31'b0, halt_s5}, 32'd0);
    check("reset_link", {31'b0, link_valid}, 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;

    // Give every word a known value.
    for (int i = 0; i < MemWords; i++) st(i * 4, 4'hF, $urandom);

    st(32'h10, 4'hF, 32'hDEADBEEF);
    ld(32'h10, 4'hF);
    check("load_after_store", wdata_s5, 32'hDEADBEEF);
    check("load_rw", {31'b0, rw_s5}, 32'd1);
    st(32'h40, 4'hF, 32'h11223344);
    st(32'h40, 4'b0010, 32'h0000AB00);
    ld(32'h40, 4'hF);
    check("byte_store", wdata_s5, 32'h1122AB44);
    ld(32'h40, 4'b0001);
    check("byte_load", wdata_s5, 32'h00000044);

    lnk(32'h20);
    sc(32'h20, 32'h55);
    check("sc_ok", wdata_s5, 32'd1);
    check("sc_ok_link", {31'b0, link_valid}, 32'd0);
    ld(32'h20, 4'hF);
    check("sc_ok_mem", wdata_s5, 32'h55);
    sc(32'h20, 32'h77);
    check("sc_again", wdata_s5, 32'd0);
    ld(32'h20, 4'hF);
    check("sc_again_mem", wdata_s5, 32'h55);

    lnk(32'h20);
    st(32'h20, 4'hF, 32'h11);
    sc(32'h20, 32'h66);
    check("sc_after_clobber", wdata_s5, 32'd0);
    ld(32'h20, 4'hF);
    check("sc_clobber_mem", wdata_s5, 32'h11);
    lnk(32'h20);
    st(32'h24, 4'hF, 32'h12);
    sc(32'h20, 32'h66);
    check("sc_other_store", wdata_s5, 32'd1);
    lnk(32'h28);
    st(32'h28, 4'h0, 32'hFFFF_FFFF);
    sc(32'h28, 32'h1);
    check("sc_after_be0", wdata_s5, 32'd0);
    lnk(32'h2C);
    lnk(32'h34);
    sc(32'h2C, 32'h1);
    check("sc_old_link", wdata_s5, 32'd0);

    st(MemWords * 4 + 8, 4'hF, 32'hCAFEF00D);
    ld(32'h8, 4'hF);
    check("addr_wrap", wdata_s5, 32'hCAFEF00D);
    step(1, 1, 0, 0, 1, 5'd7, 4'hF, 32'h5A5A5A5A, 32'h44, 0);

    // Random mix over a few hot words so links hit and miss.
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 5);
      a  = ($urandom_range(0, 7) << 2) | ($urandom & 3) | ($urandom_range(0, 3) << 10);
      case (op)
        0: step(0, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 0);
        1: step(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, a, 0);
        2: step(1, 0, 1, 0, $urandom, $urandom, $urandom, $urandom, a, 0);
        3: step(0, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, a, 0);
        4: step(0, 1, 0, 1, $urandom, $urandom, $urandom, $urandom, a, 0);
        default: step(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, a, 0);
      endcase
    end

    reset_mid_store(32'h10, 32'h0BAD0BAD);
    ld(32'h10, 4'hF);

    lnk(32'h30);
    step(0, 0, 0, 0, 1, 5'd6, 4'h0, 32'h0, 32'h1234, 1);
    check("halt_own_rw", {31'b0, rw_s5}, 32'd1);
    check("halt_set", {31'b0, halt_s5}, 32'd1);
    st(32'h30, 4'hF, 32'h99);
    step(0, 0, 0, 0, 1, 5'd8, 4'h0, 32'h0, 32'h77, 0);
    check("halted_rw", {31'b0, rw_s5}, 32'd0);
    sc(32'h30, 32'hAA);
    lnk(32'h38);
    for (int n = 0; n < 20; n++)
      step($urandom, 0, 0, 0, 1, $urandom, $urandom, $urandom, $urandom, $urandom);
    check("halt_sticky", {31'b0, halt_s5}, 32'd1);
    reset_mid_store(32'h30, 32'h0BAD0BAD);
    ld(32'h30, 4'hF);
    check("halted_store_dropped", {31'b0, wdata_s5 == 32'h99}, 32'd0);
    st(32'h30, 4'hF, 32'h99);
    ld(32'h30, 4'hF);
    check("store_after_unhalt", wdata_s5, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage (s4) of the five-stage pipeline, fed directly by the EX/MEM pipeline register. It owns the byte-enabled data memory and the load-link/store-conditional link register. It registers the write-back bundle (s5) for the register file. A sticky halt blocks architectural side effects once a halt instruction reaches this stage.

## Interface
Parameters:
- BITS, 32, data/word width
- REG_WORDS, 32, register file depth
- ADDR_LEFT, $clog2(REG_WORDS)-1, MSB of register address
- MEM_WORDS, 256, data memory depth in words (power of two)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_  in  1  async active-low reset
- sel_mem_s4  in  1  instruction is a load (result comes from memory)
- mem_rw_s4  in  1  1 = store, 0 = no store
- load_link_s4  in  1  load is LL (with sel_mem_s4)
- check_link_s4  in  1  store is SC (with mem_rw_s4)
- rw_s4  in  1  instruction writes a register
- waddr_s4  in  ADDR_LEFT+1  destination register
- byte_en_s4  in  4  byte-lane enables, bit i = bits [8i+7:8i]
- r2_data_s4  in  BITS  store data
- alu_out_s4  in  BITS  effective byte address, or ALU result
- halt_s4  in  1  halt instruction in s4
- rw_s5  out  1  register write enable to WB
- waddr_s5  out  ADDR_LEFT+1  write-back register
- wdata_s5  out  BITS  write-back data
- halt_s5  out  1  sticky halted indication
- link_valid  out  1  link register valid (debug/verification)

## Operation
- Word index = alu_out_s4[$clog2(MEM_WORDS)+1:2]. Upper bits are ignored (wrap modulo MEM_WORDS). Bits [1:0] are ignored; there is no misalignment trap.
- Read is combinational from the array. Load data = memory word with lanes whose byte_en_s4 bit is 0 forced to zero. No lane shifting or sign extension.
- Plain store (mem_rw_s4=1, check_link_s4=0): at posedge, write only the enabled lanes of r2_data_s4. If word index == link_addr, clear link_valid.
- LL (sel_mem_s4=1, load_link_s4=1): perform a normal load. At posedge, set link_valid=1 and link_addr=word index.
- SC (mem_rw_s4=1, check_link_s4=1):
  - success = link_valid && link_addr == word index.
  - On success, perform the byte-enabled store.
  - wdata_s5 = 1 on success, 0 on failure.
  - link_valid clears at posedge in both cases.
- wdata_s5 source: SC result if SC; else load data if sel_mem_s4; else alu_out_s4.
- sel_mem_s4 and mem_rw_s4 both high is illegal. In that case the store still happens, and wdata_s5 is load data of the pre-store contents.
- Halt:
  - halt_s4=1 sets the internal halted flag at posedge, and halt_s5 follows.
  - The halting instruction's own effects proceed normally.
  - While halted, all stores, SC stores and link updates are suppressed, rw_s5 is forced to 0, and halt_s5 stays 1 until reset.
- Memory contents are not reset.

## Timing
- Reset (async, immediate): rw_s5=0, waddr_s5=0, wdata_s5=0, halt_s5=0, link_valid=0, link_addr=0, halted=0.
- Latency:
  - s4 inputs appear on the s5 outputs one clock later.
  - A store in cycle N is visible to a load in s4 in cycle N+1.
  - A load in the same cycle as the store sees the old data.
- No stall or handshake: one instruction is accepted every cycle.
- Reset asserted mid-store: if the reset edge precedes the clock edge, the write is dropped. The link is invalidated regardless.
- SC immediately following LL (back-to-back cycles) to the same word succeeds.
- LL then a plain store to a different word: link is retained. A plain store to the same word: link is lost and the next SC fails.
- Second LL before SC: link_addr is overwritten with the newer address.
- byte_en_s4=4'b0000 store: no array change, but the link-clear rule still applies.

## Test plan
- Store 0xDEADBEEF to addr 0x10 with byte_en=1111, then load 0x10 with byte_en=1111 next cycle -> wdata_s5=0xDEADBEEF, rw_s5 as driven, one cycle after the load.
- Store byte_en=0010, r2=0x0000AB00 over 0x11223344, then load all lanes -> 0x1122AB44. Load with byte_en=0001 -> 0x00000044.
- LL 0x20, then SC 0x20 with r2=0x55 -> wdata_s5=1, memory = 0x55, link_valid=0. A second SC to 0x20 -> wdata_s5=0 and memory unchanged.
- LL 0x20, plain store to 0x20, SC 0x20 -> SC returns 0 and the SC data is not written. Repeat with the plain store to 0x24 -> SC returns 1.
- Address alu_out=MEM_WORDS*4+8 store, then load alu_out=8 -> same data (wrap).
- halt_s4 pulse, then store 0x99 to 0x30 and ALU op rw_s4=1 -> halt_s5=1 persists, rw_s5=0, load after reset-free re-check shows 0x30 unchanged. Async rst_ low clears halt_s5, rw_s5 and link_valid immediately, without a clock.
